// File: rtl/hex_count4.sv
// Four-digit hex up/down counter stepped by rising edges of a slow level input
// sampled in the clk_in domain; drives packed nibbles to the display mux.
module hex_count4 #(
  parameter int                 DIGITS     = 4,
  parameter logic [4*DIGITS-1:0] INIT_VALUE = '0
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  tick_in,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  step_pulse,
  output logic                  wrap
);

  localparam int W = 4 * DIGITS;

  logic          tick_q;
  logic          step;
  logic [W-1:0]  next_count;
  logic          chain;

  assign step = tick_in & ~tick_q;

  // Nibble-wise carry/borrow chain; chain exits high only when every digit wrapped.
  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    next_count = count;
    chain      = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (chain) begin
        if (up_down) begin
          if (count[4*k +: 4] == 4'hF) begin
            next_count[4*k +: 4] = 4'h0;
          end else begin
            next_count[4*k +: 4] = count[4*k +: 4] + 4'h1;
            chain                = 1'b0;
          end
        end else begin
          if (count[4*k +: 4] == 4'h0) begin
            next_count[4*k +: 4] = 4'hF;
          end else begin
            next_count[4*k +: 4] = count[4*k +: 4] - 4'h1;
            chain                = 1'b0;
          end
        end
      end
    end
  end

  // tick_q resets high so a tick_in already high at reset release is not an edge.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      count      <= INIT_VALUE;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
      tick_q     <= 1'b1;
    end else begin
      tick_q     <= tick_in;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
      if (load) begin
        count <= load_value;
      end else if (step && enable) begin
        count      <= next_count;
        step_pulse <= 1'b1;
        wrap       <= chain;
      end
    end
  end

endmodule

// File: tb/tb_hex_count4.sv
// Directed bench for hex_count4: edge detection, digit roll-over, wrap,
// enable gating, load priority and mid-run reset.
module tb_hex_count4;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        tick_in;
  logic        enable;
  logic        up_down;
  logic        load;
  logic [15:0] load_value;
  logic [15:0] count;
  logic        step_pulse;
  logic        wrap;

  int n_checks = 0;
  int n_fail   = 0;

  hex_count4 #(.DIGITS(4), .INIT_VALUE(16'h0000)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .tick_in    (tick_in),
    .enable     (enable),
    .up_down    (up_down),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .step_pulse (step_pulse),
    .wrap       (wrap)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then observed 1 ns after the edge.
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // 3 cycles high, 5 low; outputs checked in the cycle after the rise.
  task automatic pulse(input string tag, input logic [15:0] exp_count,
                       input logic exp_step, input logic exp_wrap);
    tick_in = 1'b1;
    cyc();
    check({tag, " count"}, count, exp_count);
    check({tag, " step"},  {15'd0, step_pulse}, {15'd0, exp_step});
    check({tag, " wrap"},  {15'd0, wrap}, {15'd0, exp_wrap});
    cyc();
    check({tag, " step_clear"}, {15'd0, step_pulse | wrap}, 16'd0);
    cyc();
    tick_in = 1'b0;
    repeat (5) cyc();
    check({tag, " hold"}, count, exp_count);
  endtask

  task automatic do_load(input string tag, input logic [15:0] v);
    load       = 1'b1;
    load_value = v;
    cyc();
    load = 1'b0;
    check({tag, " count"}, count, v);
    check({tag, " flags"}, {14'd0, step_pulse, wrap}, 16'd0);
  endtask

  initial begin
    logic seen;
    reset = 1'b1; tick_in = 1'b1; enable = 1'b1; up_down = 1'b1;
    load = 1'b0; load_value = 16'h0000;
    repeat (3) cyc();
    check("reset count", count, 16'h0000);
    check("reset flags", {14'd0, step_pulse, wrap}, 16'd0);

    // Release with tick_in already high: no step.
    reset = 1'b0;
    seen  = 1'b0;
    repeat (10) begin
      cyc();
      seen = seen | step_pulse;
    end
    check("release no step", {15'd0, seen}, 16'd0);
    check("release count", count, 16'h0000);
    tick_in = 1'b0;
    repeat (3) cyc();

    for (int i = 1; i <= 5; i++) pulse("up", 16'(i), 1'b1, 1'b0);
    check("up final", count, 16'h0005);

    do_load("load 00FF", 16'h00FF);
    pulse("roll 0100", 16'h0100, 1'b1, 1'b0);
    do_load("load FFFF", 16'hFFFF);
    pulse("wrap up", 16'h0000, 1'b1, 1'b1);

    do_load("load 0000", 16'h0000);
    up_down = 1'b0;
    pulse("wrap down", 16'hFFFF, 1'b1, 1'b1);
    pulse("down FFFE", 16'hFFFE, 1'b1, 1'b0);

    enable = 1'b0;
    for (int i = 0; i < 3; i++) pulse("disabled", 16'hFFFE, 1'b0, 1'b0);

    // Re-enable while tick_in is high: the edge is already gone.
    tick_in = 1'b1;
    cyc();
    enable = 1'b1;
    seen   = 1'b0;
    repeat (2) begin
      cyc();
      seen = seen | step_pulse;
    end
    check("reenable no step", {15'd0, seen}, 16'd0);
    check("reenable count", count, 16'hFFFE);
    tick_in = 1'b0;
    repeat (5) cyc();
    pulse("after reenable", 16'hFFFD, 1'b1, 1'b0);

    // Load wins over a coincident step; the step is discarded.
    up_down    = 1'b1;
    tick_in    = 1'b1;
    load       = 1'b1;
    load_value = 16'h1234;
    cyc();
    load = 1'b0;
    check("load+tick count", count, 16'h1234);
    check("load+tick step", {15'd0, step_pulse}, 16'd0);
    cyc();
    check("load+tick no late step", count, 16'h1234);
    tick_in = 1'b0;
    repeat (3) cyc();

    do_load("load 0ABC", 16'h0ABC);
    reset   = 1'b1;
    tick_in = 1'b1;
    cyc();
    check("mid reset count", count, 16'h0000);
    check("mid reset step", {15'd0, step_pulse}, 16'd0);
    cyc();
    reset = 1'b0;
    cyc();
    check("post reset no step", {14'd0, step_pulse, wrap}, 16'd0);
    tick_in = 1'b0;
    repeat (3) cyc();
    pulse("post reset up", 16'h0001, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
